nor_flash_responder: RTL and testbench

//  Synthesizable NOR flash target that sits on the far side of the parallel NOR bus: it samples CE#/WE#/OE#,

---
 rtl/nor_flash_responder.sv | 218 +++++++++++++++++++++
 tb/tb_nor_flash_responder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nor_flash_responder.sv
// NOR flash target model: samples CE#/WE#/OE#, address and data from a parallel NOR bus
// controller and drives read data and RY/BY#. Programming only clears bits, reads are
// gated by an access latency, and RY/BY# drops for a fixed time after each program.
// Optional chip erase is compiled in with the NOR_RESP_ERASE_EN macro.
module nor_flash_responder #(
    parameter int unsigned ADDRBITS     = 26,
    parameter int unsigned DATABITS     = 16,
    parameter int unsigned MEMBITS      = 10,
    parameter int unsigned READ_LATENCY = 8,
    parameter int unsigned PROG_BUSY    = 20,
    parameter logic [DATABITS-1:0] STATUS_WORD = 16'h0080,
    parameter int unsigned COUNTERBITS  = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                nor_ce_i,
    input  logic                nor_we_i,
    input  logic                nor_oe_i,
    input  logic [ADDRBITS-1:0] nor_addr_i,
    input  logic [DATABITS-1:0] nor_data_i,
    output logic [DATABITS-1:0] nor_data_o,
    output logic                nor_data_oe,
    output logic                nor_ry_o,
    output logic                err_o
);

    localparam int unsigned DEPTH = 2 ** MEMBITS;

    typedef enum logic [1:0] {
        StIdle,
        StWcap,
`ifdef NOR_RESP_ERASE_EN
        StErase,
`endif
        StProg
    } state_e;

    state_e state_q, state_d;

    logic [MEMBITS-1:0]     wa_q, wa_d;
    logic [DATABITS-1:0]    wd_q, wd_d;
    logic [COUNTERBITS-1:0] busy_q, busy_d;
    logic [COUNTERBITS-1:0] lat_q, lat_d;
    logic                   ry_q, ry_d;
    logic                   err_q, err_d;
    logic [ADDRBITS-1:0]    addr_prev_q;
    logic                   rd_oe_q, rd_oe_d;
    logic [DATABITS-1:0]    rd_data_q, rd_data_d;
`ifdef NOR_RESP_ERASE_EN
    logic [MEMBITS-1:0]     walk_q, walk_d;
`endif

    // Words are stored inverted so a zero power-on/configuration state reads as erased.
    logic [DATABITS-1:0] mem_n [DEPTH];
    logic                mem_we;
    logic [MEMBITS-1:0]  mem_waddr;
    logic [DATABITS-1:0] mem_wdata_n;

    logic ce_act, we_act, oe_act;
    logic rd_cond, addr_same, rd_valid;
    logic [MEMBITS-1:0] raddr;

    assign ce_act    = ~nor_ce_i;
    assign we_act    = ~nor_we_i;
    assign oe_act    = ~nor_oe_i;
    assign rd_cond   = ce_act & oe_act & ~we_act;
    assign addr_same = (nor_addr_i == addr_prev_q);
    assign raddr     = nor_addr_i[MEMBITS-1:0];

    // Next-state for the write/busy FSM, error flag, read latency and read data.
    always_comb begin
        state_d     = state_q;
        wa_d        = wa_q;
        wd_d        = wd_q;
        busy_d      = busy_q;
        ry_d        = ry_q;
        err_d       = err_q;
        mem_we      = 1'b0;
        mem_waddr   = wa_q;
        mem_wdata_n = mem_n[wa_q] | ~wd_q;
        lat_d       = '0;
        rd_valid    = 1'b0;
        rd_oe_d     = 1'b0;
        rd_data_d   = '0;
`ifdef NOR_RESP_ERASE_EN
        walk_d      = walk_q;
`endif

        // Write while busy, or WE# and OE# together, is a protocol error.
        if (ce_act && we_act && (!ry_q || oe_act)) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (ce_act && we_act && !oe_act && ry_q) begin
                    state_d = StWcap;
                    wa_d    = nor_addr_i[MEMBITS-1:0];
                    wd_d    = nor_data_i;
                end
            end
            StWcap: begin
                if (ce_act && we_act) begin
                    if (!oe_act) begin
                        wa_d = nor_addr_i[MEMBITS-1:0];
                        wd_d = nor_data_i;
                    end
                end else begin
                    ry_d   = 1'b0;
                    busy_d = '0;
`ifdef NOR_RESP_ERASE_EN
                    if (wd_q == DATABITS'(16'h0030) && (&wa_q)) begin
                        state_d = StErase;
                        walk_d  = '0;
                    end else begin
                        state_d = StProg;
                        mem_we  = 1'b1;
                    end
`else
                    state_d = StProg;
                    mem_we  = 1'b1;
`endif
                end
            end
            StProg: begin
                if (busy_q == COUNTERBITS'(PROG_BUSY - 1)) begin
                    state_d = StIdle;
                    ry_d    = 1'b1;
                    busy_d  = '0;
                end else begin
                    busy_d = busy_q + COUNTERBITS'(1);
                end
            end
`ifdef NOR_RESP_ERASE_EN
            StErase: begin
                mem_we      = 1'b1;
                mem_waddr   = walk_q;
                mem_wdata_n = '0;
                walk_d      = walk_q + MEMBITS'(1);
                if (&walk_q) begin
                    state_d = StIdle;
                    ry_d    = 1'b1;
                end
            end
`endif
            default: begin
                state_d = StIdle;
                ry_d    = 1'b1;
            end
        endcase

        // Reset wins over a commit or erase step landing on the same edge.
        if (rst_i) begin
            mem_we = 1'b0;
        end

        // Latency counter saturates so data stays valid while the read is held.
        if (rd_cond && addr_same) begin
            if (lat_q >= COUNTERBITS'(READ_LATENCY)) begin
                lat_d    = lat_q;
                rd_valid = 1'b1;
            end else begin
                lat_d = lat_q + COUNTERBITS'(1);
            end
        end

        if (rd_valid) begin
            rd_oe_d   = 1'b1;
            rd_data_d = ry_q ? ~mem_n[raddr] : STATUS_WORD;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            wa_q        <= '0;
            wd_q        <= '0;
            busy_q      <= '0;
            lat_q       <= '0;
            ry_q        <= 1'b1;
            err_q       <= 1'b0;
            addr_prev_q <= '0;
            rd_oe_q     <= 1'b0;
            rd_data_q   <= '0;
`ifdef NOR_RESP_ERASE_EN
            walk_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wa_q        <= wa_d;
            wd_q        <= wd_d;
            busy_q      <= busy_d;
            lat_q       <= lat_d;
            ry_q        <= ry_d;
            err_q       <= err_d;
            addr_prev_q <= nor_addr_i;
            rd_oe_q     <= rd_oe_d;
            rd_data_q   <= rd_data_d;
`ifdef NOR_RESP_ERASE_EN
            walk_q      <= walk_d;
`endif
        end
    end

    // Array write port; not reset so stored words survive rst_i.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_n[mem_waddr] <= mem_wdata_n;
        end
    end

    assign nor_data_o  = rd_data_q;
    assign nor_data_oe = rd_oe_q;
    assign nor_ry_o    = ry_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_nor_flash_responder.sv
// Bench for nor_flash_responder: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model of the device.
module tb_nor_flash_responder;

    localparam int RL    = 8;
    localparam int PB    = 20;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_n, we_n, oe_n;
    logic [25:0] addr;
    logic [15:0] din;
    logic [15:0] dout;
    logic        doe, ry, err;

    int n_pass  = 0;
    int n_total = 0;

    nor_flash_responder dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .nor_ce_i    (ce_n),
        .nor_we_i    (we_n),
        .nor_oe_i    (oe_n),
        .nor_addr_i  (addr),
        .nor_data_i  (din),
        .nor_data_o  (dout),
        .nor_data_oe (doe),
        .nor_ry_o    (ry),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_mem [DEPTH];
    int          m_busy, m_eptr, m_stable, m_ca;
    bit          m_erasing, m_cap, m_valid;
    logic [15:0] m_cd;
    logic [25:0] m_prev;
    logic        e_oe, e_ry, e_err;
    logic [15:0] e_data;

    task automatic model_step();
        bit ready, rd, same;
        if (rst) begin
            m_cap = 0; m_busy = 0; m_erasing = 0; m_stable = 0; m_prev = '0;
            e_oe = 0; e_data = '0; e_err = 0; e_ry = 1; m_valid = 1;
            return;
        end
        ready = (m_busy == 0);
        rd    = !ce_n && !oe_n && we_n;
        same  = (addr == m_prev);
        // Data is driven once the read has been stable for RL sampled cycles.
        e_oe   = rd && same && (m_stable >= RL);
        e_data = e_oe ? (ready ? m_mem[addr[9:0]] : 16'h0080) : 16'h0000;
        m_stable = (rd && same) ? ((m_stable < RL) ? m_stable + 1 : RL) : 0;
        if (!ce_n && !we_n && (!ready || !oe_n)) e_err = 1;
        if (!ready) begin
            if (m_erasing) begin
                m_mem[m_eptr] = 16'hFFFF;
                m_eptr++;
            end
            m_busy--;
            if (m_busy == 0) m_erasing = 0;
        end else if (!m_cap) begin
            if (!ce_n && !we_n && oe_n) begin
                m_cap = 1; m_ca = int'(addr[9:0]); m_cd = din;
            end
        end else if (!ce_n && !we_n) begin
            if (oe_n) begin
                m_ca = int'(addr[9:0]); m_cd = din;
            end
        end else begin
            m_cap = 0;
`ifdef NOR_RESP_ERASE_EN
            if (m_cd == 16'h0030 && m_ca == DEPTH - 1) begin
                m_erasing = 1; m_eptr = 0; m_busy = DEPTH;
            end else begin
                m_mem[m_ca] = m_mem[m_ca] & m_cd; m_busy = PB;
            end
`else
            m_mem[m_ca] = m_mem[m_ca] & m_cd; m_busy = PB;
`endif
        end
        m_prev = addr;
        e_ry   = (m_busy == 0);
    endtask

    // Compare on every falling edge, then advance the model with the inputs the next
    // rising edge will sample.
    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'hFFFF;
        m_valid = 0;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("cyc_ry", ry, e_ry);
                check("cyc_err", err, e_err);
                check("cyc_data_oe", doe, e_oe);
                check("cyc_data", dout, e_data);
            end
            model_step();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic w, input logic o,
                         input logic [25:0] a, input logic [15:0] d);
        ce_n = c; we_n = w; oe_n = o; addr = a; din = d;
    endtask

    task automatic write_op(input logic [25:0] a, input logic [15:0] d, input int n,
                            output int low_cycles, output bit first_low);
        int guard;
        drive(0, 0, 1, a, d);
        repeat (n) tick();
        ce_n = 1; we_n = 1;
        tick();
        first_low  = !ry;
        low_cycles = first_low ? 1 : 0;
        guard = 0;
        while (!ry && guard < 3000) begin
            tick();
            if (!ry) low_cycles++;
            guard++;
        end
    endtask

    task automatic read_op(input logic [25:0] a, output int lat, output logic [15:0] d1,
                           output logic [15:0] d2, output logic [16:0] off);
        drive(1, 1, 1, a, din);
        tick();
        ce_n = 0; oe_n = 0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!doe && lat < 40);
        d1 = dout;
        tick();
        d2 = doe ? dout : 16'hDEAD;
        ce_n = 1; oe_n = 1;
        tick();
        off = {doe, dout};
    endtask

    function automatic logic [25:0] rand_addr();
        logic [25:0] a;
        a = 26'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) a = a + 26'(1024 * $urandom_range(1, 40));
        if ($urandom_range(0, 15) == 0) a = 26'h3FF;
        return a;
    endfunction

    // ---------------- directed + random stimulus ----------------
    initial begin
        int          lowc, lat, n, kind;
        bit          fl, saw;
        logic [15:0] d1, d2;
        logic [16:0] off;

        rst = 1;
        drive(1, 1, 1, '0, '0);
        tick(); tick();
        check("rst_ry", ry, 1);
        check("rst_data_oe", doe, 0);
        check("rst_data", dout, 0);
        check("rst_err", err, 0);
        rst = 0;
        tick();

        // Program then read back.
        write_op(26'd5, 16'h00FF, 6, lowc, fl);
        check("prog_first_cycle_busy", fl, 1);
        check("prog_busy_len", lowc, PB);
        read_op(26'd5, lat, d1, d2, off);
        check("read_latency", lat, RL + 1);
        check("read_data", d1, 16'h00FF);
        check("read_hold", d2, 16'h00FF);
        check("read_release", off, 0);

        // Programming only clears bits.
        write_op(26'd5, 16'hFF0F, 4, lowc, fl);
        check("reprog_busy_len", lowc, PB);
        read_op(26'd5, lat, d1, d2, off);
        check("reprog_data", d1, 16'h000F);

        // Write attempt while busy, and read during busy.
        drive(0, 0, 1, 26'd9, 16'h1234);
        repeat (3) tick();
        ce_n = 1; we_n = 1;
        tick();
        check("busy_after_commit", ry, 0);
        drive(0, 0, 1, 26'd7, 16'h0000);
        repeat (3) tick();
        ce_n = 1; we_n = 1;
        tick();
        check("err_write_while_busy", err, 1);
        read_op(26'd9, lat, d1, d2, off);
        check("busy_read_latency", lat, RL + 1);
        check("busy_read_status", d1, 16'h0080);
        n = 0;
        while (!ry && n < 100) begin tick(); n++; end
        read_op(26'd7, lat, d1, d2, off);
        check("ignored_write_word", d1, 16'hFFFF);
        read_op(26'd9, lat, d1, d2, off);
        check("prog_word_9", d1, 16'h1234);
        check("err_sticky", err, 1);

        // Address change restarts the latency; aliasing of upper address bits.
        drive(1, 1, 1, 26'd5, din);
        tick();
        ce_n = 0; oe_n = 0;
        saw = 0;
        repeat (5) begin tick(); saw |= doe; end
        addr = 26'd6;
        repeat (8) begin tick(); saw |= doe; end
        check("addr_change_no_drive", saw, 0);
        ce_n = 1; oe_n = 1;
        tick();
        read_op(26'd1029, lat, d1, d2, off);
        check("alias_read", d1, 16'h000F);

`ifdef NOR_RESP_ERASE_EN
        write_op(26'h3FF, 16'h0030, 2, lowc, fl);
        check("erase_busy_len", lowc, DEPTH);
        read_op(26'd5, lat, d1, d2, off);
        check("erase_read5", d1, 16'hFFFF);
`else
        write_op(26'h3FF, 16'h0030, 2, lowc, fl);
        check("erase_cmd_as_prog_busy", lowc, PB);
        read_op(26'h3FF, lat, d1, d2, off);
        check("erase_cmd_as_prog_data", d1, 16'h0030);
`endif

        // Randomized traffic; the per-cycle model compare does the checking.
        for (int t = 0; t < 300; t++) begin
            kind = $urandom_range(0, 19);
            if (kind < 7) begin
                drive(0, 0, 1, rand_addr(), 16'($urandom) | 16'($urandom));
                n = $urandom_range(1, 5);
                repeat (n) begin
                    tick();
                    if ($urandom_range(0, 2) == 0) begin
                        addr = rand_addr();
                        din  = 16'($urandom) | 16'($urandom);
                    end
                end
                ce_n = 1; we_n = 1;
                repeat ($urandom_range(0, 25)) tick();
            end else if (kind < 14) begin
                drive(1, 1, 1, rand_addr(), din);
                tick();
                ce_n = 0; oe_n = 0;
                n = $urandom_range(1, 14);
                repeat (n) begin
                    tick();
                    if ($urandom_range(0, 9) == 0) addr = rand_addr();
                end
                ce_n = 1; oe_n = 1;
                tick();
            end else if (kind < 16) begin
                drive(0, 0, 0, rand_addr(), 16'($urandom));
                repeat ($urandom_range(1, 2)) tick();
                drive(1, 1, 1, addr, din);
                tick();
            end else if (kind < 19) begin
                repeat ($urandom_range(1, 10)) tick();
            end else begin
                rst = 1;
                repeat ($urandom_range(1, 2)) tick();
                rst = 0;
                tick();
            end
        end
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
